// File: rtl/uart_tx_sched.sv
// UART transmit controller: THR FIFO, baud/oversample timing and the serial frame FSM.
// Status (THRE/TEMT/level/overflow) is registered back to the UART register block.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 16,
  parameter int DLR_WIDTH  = 16
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rst_in,
  input  logic [7:0]                  thr_in,
  input  logic                        thr_wr_in,
  input  logic                        fifoen_in,
  input  logic                        txclr_in,
  input  logic [1:0]                  wls_in,
  input  logic                        stb_in,
  input  logic                        pen_in,
  input  logic                        eps_in,
  input  logic                        sp_in,
  input  logic                        bc_in,
  input  logic [DLR_WIDTH-1:0]        dlr_in,
  input  logic                        osm_in,
  input  logic                        utrst_in,
  output logic                        txd_out,
  output logic                        thre_out,
  output logic                        temt_out,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_out,
  output logic                        thr_ovf_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]        DEPTH   = LW'(FIFO_DEPTH);
  localparam logic [DLR_WIDTH-1:0] DLR_ONE = DLR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 fifoen_q, thre_q, temt_q, ovf_q, txd_q;
  state_e               state_q;
  logic [DLR_WIDTH-1:0] div_q;
  logic [3:0]           os_q;
  logic [2:0]           bit_q;
  logic [1:0]           wls_q;
  logic                 pen_q, stb_q, stop2_q, par_q;
  logic [7:0]           shift_q;

  logic [DLR_WIDTH-1:0] dlr_eff;
  logic [3:0]           os_last;
  logic [2:0]           last_bit;
  logic [7:0]           head, masked;
  logic                 div_end, os_end, bit_end, frame_done;
  logic                 clear, full, pop, push, par_calc, line_bit;

  always_comb begin
    dlr_eff    = (dlr_in == '0) ? DLR_ONE : dlr_in;
    div_end    = (div_q >= dlr_eff - DLR_ONE);
    os_last    = osm_in ? 4'd12 : 4'd15;
    os_end     = (os_q >= os_last);
    bit_end    = div_end && os_end;
    frame_done = (state_q == STOP) && bit_end && (!stb_q || stop2_q);
    // A mode change flushes the FIFO just like an explicit clear.
    clear      = txclr_in || (fifoen_in != fifoen_q);
    full       = fifoen_in ? (level_q >= DEPTH) : (level_q != '0);
    pop        = utrst_in && (level_q != '0) && ((state_q == IDLE) || frame_done);
    push       = thr_wr_in && !clear && !full;
    level_d    = clear ? '0 : level_q + LW'(push) - LW'(pop);
    head       = mem_q[rd_q];
    masked     = head & (8'hFF >> (2'd3 - wls_in));
    par_calc   = sp_in ? ~eps_in : (eps_in ? ^masked : ~^masked);
    last_bit   = {1'b0, wls_q} + 3'd4;
    line_bit   = 1'b1;
    case (state_q)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_q[0];
      PARITY:  line_bit = par_q;
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge apb_clk_in) begin
    if (!apb_rst_in && push) mem_q[wr_q] <= thr_in;
  end

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      fifoen_q <= fifoen_in;
      thre_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      fifoen_q <= fifoen_in;
      level_q  <= level_d;
      thre_q   <= (level_d == '0);
      ovf_q    <= thr_wr_in && !clear && full;
      if (clear) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Frame FSM; a pop always coincides with loading a fresh frame into START.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state_q <= IDLE;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      stb_q   <= 1'b0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      temt_q  <= 1'b1;
    end else begin
      temt_q <= (level_d == '0) && (state_q == IDLE) && !pop;
      if (!utrst_in) begin
        state_q <= IDLE;
        div_q   <= '0;
        os_q    <= '0;
        bit_q   <= '0;
        stop2_q <= 1'b0;
        txd_q   <= ~bc_in;
      end else begin
        txd_q <= line_bit & ~bc_in;
        if (pop) begin
          state_q <= START;
          div_q   <= '0;
          os_q    <= '0;
          bit_q   <= '0;
          stop2_q <= 1'b0;
          shift_q <= head;
          wls_q   <= wls_in;
          pen_q   <= pen_in;
          stb_q   <= stb_in;
          par_q   <= par_calc;
        end else begin
          if (state_q != IDLE) begin
            if (div_end) begin
              div_q <= '0;
              os_q  <= os_end ? 4'd0 : os_q + 4'd1;
            end else begin
              div_q <= div_q + DLR_ONE;
            end
          end
          case (state_q)
            START:  if (bit_end) begin
                      state_q <= DATA;
                      bit_q   <= '0;
                    end
            DATA:   if (bit_end) begin
                      if (bit_q == last_bit) begin
                        state_q <= pen_q ? PARITY : STOP;
                      end else begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                      end
                    end
            PARITY: if (bit_end) state_q <= STOP;
            STOP:   if (bit_end) begin
                      if (stb_q && !stop2_q) stop2_q <= 1'b1;
                      else                   state_q <= IDLE;
                    end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign txd_out      = txd_q;
  assign thre_out     = thre_q;
  assign temt_out     = temt_q;
  assign tx_level_out = level_q;
  assign thr_ovf_out  = ovf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a table of frame formats sampled mid-bit,
// plus hand-written sequences for reset, overflow/back-to-back, break and clear.
module tb_uart_tx_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  thrData;
  logic        thrWr, fifoEn, txClr, stb, pen, eps, sp, bc, osm, utrst;
  logic [1:0]  wls;
  logic [15:0] dlr;
  logic        txd, thre, temt, ovf;
  logic [4:0]  level;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  always #5 clock = ~clock;

  uart_tx_sched #(.FIFO_DEPTH(16), .DLR_WIDTH(16)) dut (
    .apb_clk_in(clock), .apb_rst_in(reset), .thr_in(thrData), .thr_wr_in(thrWr),
    .fifoen_in(fifoEn), .txclr_in(txClr), .wls_in(wls), .stb_in(stb),
    .pen_in(pen), .eps_in(eps), .sp_in(sp), .bc_in(bc), .dlr_in(dlr),
    .osm_in(osm), .utrst_in(utrst), .txd_out(txd), .thre_out(thre),
    .temt_out(temt), .tx_level_out(level), .thr_ovf_out(ovf)
  );

  // Each row: line format, byte, bit period and the expected frame bits (index 0 = start bit).
  typedef struct {
    logic [1:0]  wls;
    logic        pen, eps, sp, stb, osm;
    logic [15:0] dlr;
    logic [7:0]  data;
    int          period;
    int          nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitTo(input int t);
    while (cur < t) begin
      tick();
      cur++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wls = v.wls; pen = v.pen; eps = v.eps; sp = v.sp;
    stb = v.stb; osm = v.osm; dlr = v.dlr;
    tick();
  endtask

  task automatic writeByte(input logic [7:0] d);
    thrData = d;
    thrWr   = 1'b1;
    tick();
    thrWr   = 1'b0;
  endtask

  initial begin
    int zeros;
    vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 8'hA5, 16, 10, 12'h34A};
    vecs[1] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'h1F, 16, 9,  12'h1FE};
    vecs[2] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 8'h1F, 16, 9,  12'h1BE};
    vecs[3] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h3C, 32, 10, 12'h378};
    vecs[4] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 8'hC2, 13, 9,  12'h184};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'h00, 16, 11, 12'h600};

    reset = 1'b1; thrData = '0; thrWr = 1'b0; fifoEn = 1'b1; txClr = 1'b0;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; bc = 1'b0;
    dlr = 16'd1; osm = 1'b0; utrst = 1'b1;
    repeat (3) tick();
    checkOutput("reset txd", 32'(txd), 1);
    checkOutput("reset thre", 32'(thre), 1);
    checkOutput("reset temt", 32'(temt), 1);
    checkOutput("reset level", 32'(level), 0);
    checkOutput("reset ovf", 32'(ovf), 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v]);
      writeByte(vecs[v].data);
      cur = 0;
      checkOutput($sformatf("vec%0d level after write", v), 32'(level), 1);
      checkOutput($sformatf("vec%0d thre after write", v), 32'(thre), 0);
      waitTo(1);
      checkOutput($sformatf("vec%0d txd before start", v), 32'(txd), 1);
      for (int j = 0; j < vecs[v].nbits; j++) begin
        waitTo(2 + vecs[v].period * j + vecs[v].period / 2);
        checkOutput($sformatf("vec%0d bit%0d", v, j), 32'(txd), 32'(vecs[v].bits[j]));
      end
      waitTo(1 + vecs[v].nbits * vecs[v].period);
      checkOutput($sformatf("vec%0d temt before end", v), 32'(temt), 0);
      waitTo(2 + vecs[v].nbits * vecs[v].period);
      checkOutput($sformatf("vec%0d temt at end", v), 32'(temt), 1);
      checkOutput($sformatf("vec%0d txd idle", v), 32'(txd), 1);
    end

    // Overflow while held in reset, then 16 back-to-back frames of 160 cycles.
    wls = 2'b11; pen = 1'b0; stb = 1'b0; osm = 1'b0; dlr = 16'd1;
    utrst = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      writeByte(8'h10 + 8'(i));
      checkOutput($sformatf("ovf write %0d", i), 32'(ovf), (i == 16) ? 1 : 0);
    end
    tick();
    checkOutput("ovf pulse ends", 32'(ovf), 0);
    checkOutput("level full", 32'(level), 16);
    utrst = 1'b1;
    tick();
    cur = 0;
    checkOutput("level after first pop", 32'(level), 15);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        waitTo(160 * k);
        checkOutput($sformatf("b2b stop before frame %0d", k), 32'(txd), 1);
      end
      waitTo(160 * k + 1);
      checkOutput($sformatf("b2b start frame %0d", k), 32'(txd), 0);
    end
    waitTo(2560);
    checkOutput("b2b temt before end", 32'(temt), 0);
    waitTo(2561);
    checkOutput("b2b temt end", 32'(temt), 1);
    checkOutput("b2b thre end", 32'(thre), 1);

    // 13x oversampling with divisor 3 (39-cycle bits) and a break pulse mid-DATA.
    osm = 1'b1; dlr = 16'd3;
    tick();
    writeByte(8'hFF);
    cur = 0;
    waitTo(40);
    checkOutput("13x last start cycle", 32'(txd), 0);
    waitTo(41);
    checkOutput("13x first data cycle", 32'(txd), 1);
    waitTo(129);
    bc = 1'b1;
    waitTo(130);
    checkOutput("break asserted", 32'(txd), 0);
    waitTo(140);
    checkOutput("break held", 32'(txd), 0);
    bc = 1'b0;
    waitTo(141);
    checkOutput("break released", 32'(txd), 1);
    waitTo(391);
    checkOutput("13x temt before end", 32'(temt), 0);
    waitTo(392);
    checkOutput("13x temt end", 32'(temt), 1);

    // Clear with four bytes queued behind a running frame.
    osm = 1'b0; dlr = 16'd1;
    tick();
    for (int i = 0; i < 5; i++) writeByte(8'h11 * 8'(i));
    cur = 4;
    checkOutput("clear level queued", 32'(level), 4);
    waitTo(40);
    txClr = 1'b1;
    waitTo(41);
    txClr = 1'b0;
    checkOutput("clear level", 32'(level), 0);
    checkOutput("clear thre", 32'(thre), 1);
    waitTo(60);
    checkOutput("frame continues after clear", 32'(txd), 0);
    waitTo(161);
    checkOutput("clear temt before end", 32'(temt), 0);
    waitTo(162);
    checkOutput("clear temt end", 32'(temt), 1);
    waitTo(170);
    checkOutput("no frame after clear", 32'(txd), 1);

    // Clear coincident with a write to a full FIFO.
    utrst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) writeByte(8'(i));
    checkOutput("refill level", 32'(level), 16);
    thrData = 8'h99; thrWr = 1'b1; txClr = 1'b1;
    tick();
    thrWr = 1'b0; txClr = 1'b0;
    checkOutput("clear+write level", 32'(level), 0);
    checkOutput("clear+write ovf", 32'(ovf), 0);

    // Holding-register mode: capacity 1, and mode changes flush.
    fifoEn = 1'b0;
    tick();
    writeByte(8'h55);
    checkOutput("hr level", 32'(level), 1);
    checkOutput("hr first ovf", 32'(ovf), 0);
    writeByte(8'h66);
    checkOutput("hr second ovf", 32'(ovf), 1);
    checkOutput("hr level held", 32'(level), 1);
    fifoEn = 1'b1;
    tick();
    checkOutput("mode change level", 32'(level), 0);
    checkOutput("mode change thre", 32'(thre), 1);
    utrst = 1'b1;
    tick();

    // Reset in the middle of a frame with another byte queued.
    writeByte(8'h00);
    writeByte(8'h00);
    cur = 1;
    waitTo(50);
    checkOutput("pre-reset data bit", 32'(txd), 0);
    reset = 1'b1;
    tick();
    checkOutput("midframe reset txd", 32'(txd), 1);
    checkOutput("midframe reset thre", 32'(thre), 1);
    checkOutput("midframe reset temt", 32'(temt), 1);
    checkOutput("midframe reset level", 32'(level), 0);
    checkOutput("midframe reset ovf", 32'(ovf), 0);
    reset = 1'b0;
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (txd !== 1'b1) zeros++;
    end
    checkOutput("no line activity after reset", 32'(zeros), 0);
    checkOutput("temt after reset", 32'(temt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
